// File: rtl/mux_sel_arbiter_if.sv
// Purpose: bundles the request/select/grant signals between the requesters and
//          the round-robin select arbiter feeding the 4:1 mux.
// Latency: n/a (wires only).
// Backpressure: n/a; requesters hold req until they are done with the mux.
// Signals: req (4) requests; sel0/sel1 mux select {MSB,LSB}; gnt (4) one-hot
//          grant; sel_valid select points at a granted owner; switch_pulse
//          first cycle of a tenure; lock (only with MUX_SEL_ARB_LOCK_EN).
// Modports: master = requester side (drives req/lock), slave = arbiter side.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic       sel0;
  logic       sel1;
  logic [3:0] gnt;
  logic       sel_valid;
  logic       switch_pulse;
`ifdef MUX_SEL_ARB_LOCK_EN
  logic       lock;

  modport master (output req, output lock,
                  input  sel0, input sel1, input gnt, input sel_valid, input switch_pulse);
  modport slave  (input  req, input  lock,
                  output sel0, output sel1, output gnt, output sel_valid, output switch_pulse);
`else
  modport master (output req,
                  input  sel0, input sel1, input gnt, input sel_valid, input switch_pulse);
  modport slave  (input  req,
                  output sel0, output sel1, output gnt, output sel_valid, output switch_pulse);
`endif
endinterface

// File: rtl/mux_sel_arbiter.sv
// Purpose: round-robin arbiter producing the registered sel0/sel1 pair for the
//          4:1 select mux plus a one-hot grant, with per-tenure hold limit and
//          dead cycles between different owners.
// Latency: 1 cycle from req to gnt; all outputs come straight from registers.
// Backpressure: owner keeps the mux while req[o] is high, limited to HOLD_MAX
//          cycles when others wait; GAP_CYCLES idle cycles follow each release.
// Ports: clk, rst_n (async active-low), bus (mux_sel_arbiter_if.slave).
// Option: MUX_SEL_ARB_LOCK_EN adds bus.lock, which suppresses hold expiry in GRANT.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_MAX   = 8,   // 1..255
  parameter int unsigned GAP_CYCLES = 1    // 0..15
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_sel_arbiter_if.slave bus
);

  localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [3:0]    GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;     // last released owner; scan starts after it
  logic [1:0]    idx_q, idx_d;     // current / last owner, drives sel0/sel1
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    gap_q, gap_d;
  logic          pulse_q, pulse_d;

  logic          lock_w;
  logic [1:0]    arb_base;
  logic [1:0]    cand;
  logic [1:0]    win_idx;
  logic          win_vld;
  logic          others_w;
  logic          rel_w;

`ifdef MUX_SEL_ARB_LOCK_EN
  assign lock_w = bus.lock;
`else
  assign lock_w = 1'b0;
`endif

  // In GRANT the release path arbitrates as if ptr had already moved to the
  // owner, so a zero-gap switch sees the same order as a gapped one.
  always_comb begin
    arb_base = (state_q == GRANT) ? idx_q : ptr_q;
    win_vld  = 1'b0;
    win_idx  = arb_base;
    cand     = arb_base;
    // Scan ptr+4 down to ptr+1 so the nearest requester is written last.
    for (int k = 4; k >= 1; k--) begin
      cand = arb_base + 2'(k);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign others_w = (bus.req & ~(4'b0001 << idx_q)) != 4'b0000;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    pulse_d = 1'b0;
    rel_w   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          idx_d   = win_idx;
          hold_d  = '0;
          pulse_d = 1'b1;
        end
      end
      GRANT: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + HW'(1);
        if (!bus.req[idx_q]) begin
          rel_w = 1'b1;
        end else if (hold_q == HOLD_LAST && !lock_w) begin
          // Sole requester at expiry simply starts a fresh tenure in place.
          if (others_w) rel_w = 1'b1;
          else          hold_d = '0;
        end
        if (rel_w) begin
          ptr_d = idx_q;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else if (win_vld) begin
            state_d = GRANT;
            idx_d   = win_idx;
            hold_d  = '0;
            pulse_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          if (win_vld) begin
            state_d = GRANT;
            idx_d   = win_idx;
            hold_d  = '0;
            pulse_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      gap_q   <= 4'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.sel0         = idx_q[1];
  assign bus.sel1         = idx_q[0];
  assign bus.sel_valid    = (state_q == GRANT);
  assign bus.gnt          = (state_q == GRANT) ? (4'b0001 << idx_q) : 4'b0000;
  assign bus.switch_pulse = pulse_q;

endmodule
